// File: rtl/simple_processor_param_if.sv
// Handshake and shared-bus bundle for simple_processor_param.
// Zero/Carry exist only when FLAGS_EN is defined.
interface simple_processor_param_if #(
    parameter int DATA_W = 16
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic [DATA_W-1:0] Bus;
    logic              Done;
`ifdef FLAGS_EN
    logic              Zero;
    logic              Carry;
`endif

`ifdef FLAGS_EN
    modport master (output Run, DIN, input Bus, Done, Zero, Carry);
    modport slave  (input Run, DIN, output Bus, Done, Zero, Carry);
`else
    modport master (output Run, DIN, input Bus, Done);
    modport slave  (input Run, DIN, output Bus, Done);
`endif
endinterface

// File: rtl/simple_processor_param.sv
// Parametrised multi-cycle processor core: one shared bus, Run/Done handshake.
// Optional macro FLAGS_EN adds Zero/Carry flags and the mvnz instruction.
//
//  state | meaning
//  T0    | idle / fetch: IR <= DIN when Run
//  T1    | mv/mvi/mvnz/no-op execute and finish; ALU ops load A <= Rx
//  T2    | ALU: G <= A op Ry (flags updated here)
//  T3    | ALU: Rx <= G, finish
module simple_processor_param #(
    parameter int DATA_W = 16,
    parameter int RSEL_W = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    simple_processor_param_if.slave  bus_if
);
    localparam int NREG = 2**RSEL_W;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_g;
    logic [DATA_W-1:0]   r_regs [NREG];

    logic [2:0]          w_op;
    logic [RSEL_W-1:0]   w_rx;
    logic [RSEL_W-1:0]   w_ry;

    logic                w_done;
    logic                w_sel_din;
    logic                w_sel_g;
    logic [NREG-1:0]     w_sel_r;
    logic                w_ir_ld;
    logic                w_a_ld;
    logic                w_g_ld;
    logic                w_rx_ld;
    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W:0]     w_alu;

`ifdef FLAGS_EN
    logic                r_zero;
    logic                r_carry;
`else
    logic                w_unused_carry;
`endif

    assign w_op = r_ir[DATA_W-1 -: 3];
    assign w_rx = r_ir[DATA_W-4 -: RSEL_W];
    assign w_ry = r_ir[DATA_W-4-RSEL_W -: RSEL_W];

    generate
        if (DATA_W > 3 + 2*RSEL_W) begin : g_ir_spare
            logic w_unused_ir;
            assign w_unused_ir = ^r_ir[DATA_W-4-2*RSEL_W:0];
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= T0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_sel_din   = 1'b0;
        w_sel_g     = 1'b0;
        w_sel_r     = '0;
        w_ir_ld     = 1'b0;
        w_a_ld      = 1'b0;
        w_g_ld      = 1'b0;
        w_rx_ld     = 1'b0;
        case (r_state)
            T0: begin
                if (bus_if.Run) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = T1;
                end
            end
            T1: begin
                w_state_nxt = T0;
                case (w_op)
                    OP_MV: begin
                        w_sel_r[w_ry] = 1'b1;
                        w_rx_ld       = 1'b1;
                        w_done        = 1'b1;
                    end
                    OP_MVI: begin
                        w_sel_din = 1'b1;
                        w_rx_ld   = 1'b1;
                        w_done    = 1'b1;
                    end
                    OP_MVNZ: begin
`ifdef FLAGS_EN
                        if (!r_zero) begin
                            w_sel_r[w_ry] = 1'b1;
                            w_rx_ld       = 1'b1;
                        end
`endif
                        w_done = 1'b1;
                    end
                    default: begin
                        w_sel_r[w_rx] = 1'b1;
                        w_a_ld        = 1'b1;
                        w_state_nxt   = T2;
                    end
                endcase
            end
            T2: begin
                w_sel_r[w_ry] = 1'b1;
                w_g_ld        = 1'b1;
                w_state_nxt   = T3;
            end
            T3: begin
                w_sel_g     = 1'b1;
                w_rx_ld     = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = T0;
            end
            default: w_state_nxt = T0;
        endcase
    end

    // One-hot OR mux: with no select active the bus reads zero.
    always_comb begin
        w_bus = '0;
        if (w_sel_din) w_bus = w_bus | bus_if.DIN;
        if (w_sel_g)   w_bus = w_bus | r_g;
        for (int i = 0; i < NREG; i++) begin
            if (w_sel_r[i]) w_bus = w_bus | r_regs[i];
        end
    end

    // Extra top bit is the add carry or the sub borrow.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, w_bus};
            OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, w_bus};
            OP_AND:  w_alu = {1'b0, r_a & w_bus};
            OP_OR:   w_alu = {1'b0, r_a | w_bus};
            OP_XOR:  w_alu = {1'b0, r_a ^ w_bus};
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (w_ir_ld) r_ir         <= bus_if.DIN;
            if (w_a_ld)  r_a          <= w_bus;
            if (w_g_ld)  r_g          <= w_alu[DATA_W-1:0];
            if (w_rx_ld) r_regs[w_rx] <= w_bus;
        end
    end

`ifdef FLAGS_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_g_ld) begin
            r_zero  <= (w_alu[DATA_W-1:0] == '0);
            r_carry <= w_alu[DATA_W];
        end
    end

    assign bus_if.Zero  = r_zero;
    assign bus_if.Carry = r_carry;
`else
    assign w_unused_carry = w_alu[DATA_W];
`endif

    assign bus_if.Bus  = w_bus;
    assign bus_if.Done = w_done;
endmodule

// File: tb/tb_simple_processor_param.sv
// Directed bench for simple_processor_param (DATA_W=16, RSEL_W=3); FLAGS_EN-aware.
module tb_simple_processor_param;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    simple_processor_param_if #(.DATA_W(16)) u_if ();

    simple_processor_param #(.DATA_W(16), .RSEL_W(3)) u_dut (
        .Clock  (clk),
        .Reset  (rst),
        .bus_if (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [15:0] imm;
        logic        alu;
        logic [15:0] bus;
        logic        z;
        logic        c;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1 with the core in T0.
    task automatic do_instr(input string nm, input logic [15:0] word, input logic [15:0] imm,
                            input logic alu, input logic drop_run, input logic [15:0] exp_bus,
                            input logic ez, input logic ec);
        u_if.Run = 1'b1;
        u_if.DIN = word;
        #1;
        chk({nm, " T0 bus"}, u_if.Bus, 16'h0000);
        chk({nm, " T0 done"}, {15'd0, u_if.Done}, 16'h0000);
        @(posedge clk); #1;
        u_if.DIN = imm;
        if (drop_run) u_if.Run = 1'b0;
        #1;
        if (alu) begin
            chk({nm, " T1 done"}, {15'd0, u_if.Done}, 16'h0000);
            @(posedge clk); #1;
            chk({nm, " T2 done"}, {15'd0, u_if.Done}, 16'h0000);
            @(posedge clk); #2;
        end
        chk({nm, " done"}, {15'd0, u_if.Done}, 16'h0001);
        chk({nm, " bus"}, u_if.Bus, exp_bus);
`ifdef FLAGS_EN
        chk({nm, " zero"}, {15'd0, u_if.Zero}, {15'd0, ez});
        chk({nm, " carry"}, {15'd0, u_if.Carry}, {15'd0, ec});
`else
        if (ez === 1'bx || ec === 1'bx) $display("note: unused flag expectation");
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{16'h2000, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0}; // mvi R0,5
        tbl[1]  = '{16'h2800, 16'h0007, 1'b0, 16'h0007, 1'b0, 1'b0}; // mvi R2,7
        tbl[2]  = '{16'h6100, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b1}; // sub R0,R2
        tbl[3]  = '{16'h4100, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b1}; // add R0,R2
        tbl[4]  = '{16'h0C00, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b1}; // mv R3,R0
        tbl[5]  = '{16'h8100, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b0}; // and R0,R2
        tbl[6]  = '{16'hAD00, 16'h0000, 1'b1, 16'h0007, 1'b0, 1'b0}; // or R3,R2
        tbl[7]  = '{16'hCD00, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0}; // xor R3,R2
        tbl[8]  = '{16'h4900, 16'h0000, 1'b1, 16'h000E, 1'b0, 1'b0}; // add R2,R2
        tbl[9]  = '{16'h6900, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0}; // sub R2,R2
        tbl[10] = '{16'h3C00, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b0}; // mvi R7,FFFF
        tbl[11] = '{16'h5C00, 16'h0000, 1'b1, 16'h0004, 1'b0, 1'b1}; // add R7,R0
        tbl[12] = '{16'h0780, 16'h0000, 1'b0, 16'h0004, 1'b0, 1'b1}; // mv R1,R7

        rst      = 1'b1;
        u_if.Run = 1'b0;
        u_if.DIN = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset bus", u_if.Bus, 16'h0000);
        chk("reset done", {15'd0, u_if.Done}, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle bus", u_if.Bus, 16'h0000);
`ifdef FLAGS_EN
        chk("reset flags", {14'd0, u_if.Zero, u_if.Carry}, 16'h0000);
`endif

        for (int i = 0; i < 13; i++) begin
            do_instr($sformatf("vec%0d", i), tbl[i].word, tbl[i].imm, tbl[i].alu, 1'b0,
                     tbl[i].bus, tbl[i].z, tbl[i].c);
        end

        // State here: R0=5 R1=4 R7=4, others 0; Zero=0 Carry=1.
`ifdef FLAGS_EN
        do_instr("mvnz copy", 16'hE800, 16'h0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b1);
        do_instr("rd R2 after mvnz", 16'h1100, 16'h0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b1);
`else
        do_instr("op111 nop", 16'hE800, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        do_instr("rd R2 after nop", 16'h1100, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif
        do_instr("sub R1,R1", 16'h6480, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_instr("mvnz zero", 16'hEC00, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_instr("rd R3 after mvnz", 16'h1580, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Run dropped during T1 must not abort the mv.
        do_instr("mv run drop", 16'h0C00, 16'h0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("idle%0d bus", k), u_if.Bus, 16'h0000);
            chk($sformatf("idle%0d done", k), {15'd0, u_if.Done}, 16'h0000);
            @(posedge clk); #1;
        end

        // Reset pulse while an add sits in T2.
        u_if.Run = 1'b1;
        u_if.DIN = 16'h4000;
        @(posedge clk); #1;
        u_if.Run = 1'b0;
        @(posedge clk); #1;
        chk("T2 before reset done", {15'd0, u_if.Done}, 16'h0000);
        rst = 1'b1;
        #2;
        chk("midreset bus", u_if.Bus, 16'h0000);
        chk("midreset done", {15'd0, u_if.Done}, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post reset bus", u_if.Bus, 16'h0000);
        chk("post reset done", {15'd0, u_if.Done}, 16'h0000);
`ifdef FLAGS_EN
        chk("post reset flags", {14'd0, u_if.Zero, u_if.Carry}, 16'h0000);
`endif
        for (int k = 0; k < 8; k++) begin
            logic [15:0] w;
            w = 16'h0000;
            w[9:7] = k[2:0];
            do_instr($sformatf("rd R%0d after reset", k), w, 16'h0, 1'b0, 1'b0,
                     16'h0000, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
